// File: rtl/sd_spi_master.sv
// sd_spi_master: memory-mapped SPI (mode 0, MSB first) master for the SD card.
// Four byte registers behind the CPU decoder; spi_ack stalls the CPU while a
// byte is in flight, except for STATUS which always answers immediately.
module sd_spi_master #(
    parameter logic [7:0] DIV_DEFAULT = 8'd63
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    input  logic       spi_stb,
    input  logic       spi_wr,
    output logic       spi_ack,
    output logic [7:0] spi_data,
    output logic       sd_sclk,
    output logic       sd_mosi,
    input  logic       sd_miso,
    output logic       sd_cs_n
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_CLKDIV = 2'd3;

    state_t     state, state_nx;
    logic       busy;
    logic       cs;
    logic [7:0] clkdiv;
    logic [7:0] rxbuf;
    logic [7:0] shift;
    logic [2:0] bitcnt;
    logic [7:0] divcnt;
    logic       rxbit;

    logic       accept, wr_acc, rd_acc, start, div_zero;
    logic [7:0] rd_mux;

    // STATUS is never stalled so software can poll busy mid-byte.
    assign spi_ack  = ~spi_stb | ~busy | (addr == A_STATUS);
    assign accept   = spi_stb & spi_ack;
    assign wr_acc   = accept & spi_wr;
    assign rd_acc   = accept & ~spi_wr;
    assign start    = wr_acc & (addr == A_DATA) & (state == IDLE);
    assign div_zero = (divcnt == 8'd0);
    assign sd_cs_n  = ~cs;

    // Read mux of the register selected by addr
    always_comb begin
        rd_mux = 8'h00;
        case (addr)
            A_DATA:   rd_mux = rxbuf;
            A_STATUS: rd_mux = {6'b0, cs, busy};
            A_CTRL:   rd_mux = {7'b0, cs};
            A_CLKDIV: rd_mux = clkdiv;
            default:  rd_mux = 8'h00;
        endcase
    end

    // Transfer FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Transfer FSM next state: each SCLK phase lasts CLKDIV+1 cycles
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOW;
            LOW:     if (div_zero) state_nx = HIGH;
            HIGH:    if (div_zero) state_nx = (bitcnt == 3'd0) ? IDLE : LOW;
            default: state_nx = IDLE;
        endcase
    end

    // Shifter, divider and SPI pins; MOSI only moves at start or on SCLK fall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy    <= 1'b0;
            sd_sclk <= 1'b0;
            sd_mosi <= 1'b1;
            shift   <= 8'h00;
            bitcnt  <= 3'd0;
            divcnt  <= 8'd0;
            rxbit   <= 1'b0;
            rxbuf   <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift   <= wdata;
                        bitcnt  <= 3'd7;
                        divcnt  <= clkdiv;
                        busy    <= 1'b1;
                        sd_mosi <= wdata[7];
                        sd_sclk <= 1'b0;
                    end
                end
                LOW: begin
                    if (div_zero) begin
                        sd_sclk <= 1'b1;
                        rxbit   <= sd_miso;
                        divcnt  <= clkdiv;
                    end else begin
                        divcnt  <= divcnt - 8'd1;
                    end
                end
                HIGH: begin
                    if (div_zero) begin
                        sd_sclk <= 1'b0;
                        shift   <= {shift[6:0], rxbit};
                        divcnt  <= clkdiv;
                        if (bitcnt == 3'd0) begin
                            rxbuf   <= {shift[6:0], rxbit};
                            busy    <= 1'b0;
                            sd_mosi <= 1'b1;
                        end else begin
                            bitcnt  <= bitcnt - 3'd1;
                            sd_mosi <= shift[6];
                        end
                    end else begin
                        divcnt  <= divcnt - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // CTRL/CLKDIV writes; ack gating keeps these from landing mid-byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs     <= 1'b0;
            clkdiv <= DIV_DEFAULT;
        end else if (wr_acc) begin
            if (addr == A_CTRL)   cs     <= wdata[0];
            if (addr == A_CLKDIV) clkdiv <= wdata;
        end
    end

    // Read data register, updated only by accepted reads
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      spi_data <= 8'h00;
        else if (rd_acc) spi_data <= rd_mux;
    end

endmodule

// File: tb/tb_sd_spi_master.sv
// tb_sd_spi_master: directed scenario tests for sd_spi_master.
module tb_sd_spi_master;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] wdata = 8'h00;
    logic       spi_stb = 1'b0;
    logic       spi_wr = 1'b0;
    logic       spi_ack;
    logic [7:0] spi_data;
    logic       sd_sclk, sd_mosi, sd_miso, sd_cs_n;

    logic       miso_loop = 1'b1;
    logic       miso_val = 1'b0;
    assign sd_miso = miso_loop ? sd_mosi : miso_val;

    int vecs = 0;
    int errs = 0;

    sd_spi_master #(.DIV_DEFAULT(8'd63)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .spi_stb(spi_stb), .spi_wr(spi_wr), .spi_ack(spi_ack),
        .spi_data(spi_data), .sd_sclk(sd_sclk), .sd_mosi(sd_mosi),
        .sd_miso(sd_miso), .sd_cs_n(sd_cs_n)
    );

    always #5 clk = ~clk;

    // SCLK pulse counter and MOSI capture on rising SCLK
    int         pulses = 0;
    logic [7:0] mosi_cap = 8'h00;
    always @(posedge sd_sclk) begin
        pulses   = pulses + 1;
        mosi_cap = {mosi_cap[6:0], sd_mosi};
    end

    // SCLK phase-length statistics, sampled mid-cycle
    logic stat_clr = 1'b0;
    logic prev_sclk = 1'b0;
    logic seen_fall = 1'b0;
    int   run = 0;
    int   hi_min = 9999, hi_max = 0, lo_min = 9999, lo_max = 0;
    always @(negedge clk) begin
        if (stat_clr) begin
            hi_min = 9999; hi_max = 0; lo_min = 9999; lo_max = 0;
            seen_fall = 1'b0; run = 1;
        end else if (sd_sclk !== prev_sclk) begin
            if (prev_sclk) begin
                if (run < hi_min) hi_min = run;
                if (run > hi_max) hi_max = run;
                seen_fall = 1'b1;
            end else if (seen_fall) begin
                if (run < lo_min) lo_min = run;
                if (run > lo_max) lo_max = run;
            end
            run = 1;
        end else begin
            run = run + 1;
        end
        prev_sclk = sd_sclk;
    end

    // One bus access; returns the number of ack-low cycles before acceptance
    task automatic access(input logic [1:0] a, input logic w, input logic [7:0] d,
                          input int max_wait, output int stalls);
        stalls = 0;
        @(negedge clk);
        spi_stb = 1'b1; spi_wr = w; addr = a; wdata = d;
        #1;
        while (!spi_ack && stalls < max_wait) begin
            @(negedge clk); #1;
            stalls++;
        end
        @(posedge clk); #1;
        spi_stb = 1'b0; spi_wr = 1'b0;
    endtask

    // Back-to-back STATUS reads; n = number of reads reporting busy
    task automatic poll_busy(input int max_reads, output int n, output logic [7:0] first);
        n = 0;
        first = 8'h00;
        spi_stb = 1'b1; spi_wr = 1'b0; addr = 2'd1;
        for (int i = 0; i < max_reads; i++) begin
            @(posedge clk); #1;
            if (i == 0) first = spi_data;
            if (!spi_data[0]) break;
            n++;
        end
        spi_stb = 1'b0;
    endtask

    task automatic clear_stats();
        @(negedge clk); stat_clr = 1'b1;
        @(negedge clk); stat_clr = 1'b0;
    endtask

    task automatic test_reset();
        int s;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vecs++; if (sd_cs_n !== 1'b1) begin errs++; $display("FAIL rst_cs_n: got %b want 1", sd_cs_n); end
        vecs++; if (sd_sclk !== 1'b0) begin errs++; $display("FAIL rst_sclk: got %b want 0", sd_sclk); end
        vecs++; if (sd_mosi !== 1'b1) begin errs++; $display("FAIL rst_mosi: got %b want 1", sd_mosi); end
        vecs++; if (spi_ack !== 1'b1) begin errs++; $display("FAIL rst_ack: got %b want 1", spi_ack); end
        vecs++; if (spi_data !== 8'h00) begin errs++; $display("FAIL rst_data: got %h want 00", spi_data); end
        reset = 1'b1;
        access(2'd3, 1'b0, 8'h00, 10, s);
        vecs++; if (spi_data !== 8'h3F) begin errs++; $display("FAIL rst_clkdiv: got %h want 3f", spi_data); end
        access(2'd1, 1'b0, 8'h00, 10, s);
        vecs++; if (spi_data !== 8'h00) begin errs++; $display("FAIL rst_status: got %h want 00", spi_data); end
    endtask

    task automatic test_loopback();
        int s, n, p0;
        logic [7:0] first;
        miso_loop = 1'b1;
        access(2'd2, 1'b1, 8'h01, 10, s);
        vecs++; if (sd_cs_n !== 1'b0) begin errs++; $display("FAIL cs_assert: got %b want 0", sd_cs_n); end
        access(2'd3, 1'b1, 8'h00, 10, s);
        p0 = pulses;
        access(2'd0, 1'b1, 8'hA5, 10, s);
        vecs++; if (s != 0) begin errs++; $display("FAIL idle_write_stall: got %0d want 0", s); end
        poll_busy(100, n, first);
        vecs++; if (first !== 8'h03) begin errs++; $display("FAIL status_mid: got %h want 03", first); end
        vecs++; if (n != 16) begin errs++; $display("FAIL busy_len_div0: got %0d want 16", n); end
        vecs++; if (pulses - p0 != 8) begin errs++; $display("FAIL pulses_div0: got %0d want 8", pulses - p0); end
        vecs++; if (mosi_cap !== 8'hA5) begin errs++; $display("FAIL mosi_bits: got %h want a5", mosi_cap); end
        vecs++; if (sd_mosi !== 1'b1) begin errs++; $display("FAIL mosi_idle: got %b want 1", sd_mosi); end
        access(2'd0, 1'b0, 8'h00, 10, s);
        vecs++; if (spi_data !== 8'hA5) begin errs++; $display("FAIL rx_loop: got %h want a5", spi_data); end
    endtask

    task automatic test_slow_div();
        int s, n, p0;
        logic [7:0] first;
        access(2'd3, 1'b1, 8'h03, 10, s);
        miso_loop = 1'b0; miso_val = 1'b1;
        clear_stats();
        p0 = pulses;
        access(2'd0, 1'b1, 8'h00, 10, s);
        poll_busy(200, n, first);
        vecs++; if (n != 64) begin errs++; $display("FAIL busy_len_div3: got %0d want 64", n); end
        vecs++; if (pulses - p0 != 8) begin errs++; $display("FAIL pulses_div3: got %0d want 8", pulses - p0); end
        vecs++; if (mosi_cap !== 8'h00) begin errs++; $display("FAIL mosi_zero: got %h want 00", mosi_cap); end
        vecs++; if (hi_min != 4 || hi_max != 4) begin errs++; $display("FAIL sclk_high: got %0d..%0d want 4", hi_min, hi_max); end
        vecs++; if (lo_min != 4 || lo_max != 4) begin errs++; $display("FAIL sclk_low: got %0d..%0d want 4", lo_min, lo_max); end
        access(2'd0, 1'b0, 8'h00, 10, s);
        vecs++; if (spi_data !== 8'hFF) begin errs++; $display("FAIL rx_ones: got %h want ff", spi_data); end
        access(2'd3, 1'b1, 8'h00, 10, s);
        miso_loop = 1'b1;
    endtask

    task automatic test_read_stall();
        int s;
        access(2'd0, 1'b1, 8'h81, 10, s);
        access(2'd0, 1'b0, 8'h00, 100, s);
        vecs++; if (s != 16) begin errs++; $display("FAIL read_stall: got %0d want 16", s); end
        vecs++; if (spi_data !== 8'h81) begin errs++; $display("FAIL read_after_stall: got %h want 81", spi_data); end
    endtask

    task automatic test_back_to_back();
        int s, n, p0;
        logic [7:0] first;
        p0 = pulses;
        access(2'd0, 1'b1, 8'h5A, 10, s);
        access(2'd0, 1'b1, 8'hC3, 100, s);
        vecs++; if (s != 16) begin errs++; $display("FAIL b2b_stall: got %0d want 16", s); end
        poll_busy(100, n, first);
        vecs++; if (n != 16) begin errs++; $display("FAIL b2b_busy: got %0d want 16", n); end
        vecs++; if (pulses - p0 != 16) begin errs++; $display("FAIL b2b_pulses: got %0d want 16", pulses - p0); end
        vecs++; if (mosi_cap !== 8'hC3) begin errs++; $display("FAIL b2b_mosi: got %h want c3", mosi_cap); end
        access(2'd0, 1'b0, 8'h00, 10, s);
        vecs++; if (spi_data !== 8'hC3) begin errs++; $display("FAIL b2b_rx: got %h want c3", spi_data); end
    endtask

    task automatic test_ctrl_stall();
        int s, n, bad;
        access(2'd0, 1'b1, 8'h3C, 10, s);
        vecs++; if (spi_data !== 8'hC3) begin errs++; $display("FAIL write_keeps_data: got %h want c3", spi_data); end
        @(negedge clk);
        spi_stb = 1'b1; spi_wr = 1'b1; addr = 2'd2; wdata = 8'h00;
        #1;
        n = 0; bad = 0;
        while (!spi_ack && n < 100) begin
            if (sd_cs_n !== 1'b0) bad++;
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        spi_stb = 1'b0; spi_wr = 1'b0;
        vecs++; if (n != 16) begin errs++; $display("FAIL ctrl_stall: got %0d want 16", n); end
        vecs++; if (bad != 0) begin errs++; $display("FAIL cs_mid_byte: got %0d changes want 0", bad); end
        vecs++; if (sd_cs_n !== 1'b1) begin errs++; $display("FAIL cs_deassert: got %b want 1", sd_cs_n); end
        access(2'd2, 1'b0, 8'h00, 10, s);
        vecs++; if (spi_data !== 8'h00) begin errs++; $display("FAIL ctrl_read: got %h want 00", spi_data); end
    endtask

    task automatic test_reset_mid();
        int s, n, p0;
        logic [7:0] first;
        access(2'd2, 1'b1, 8'h01, 10, s);
        access(2'd3, 1'b1, 8'h01, 10, s);
        p0 = pulses;
        access(2'd0, 1'b1, 8'hF0, 10, s);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pulses - p0 >= 3) break;
        end
        vecs++; if (pulses - p0 != 3) begin errs++; $display("FAIL mid_pulses: got %0d want 3", pulses - p0); end
        #2 reset = 1'b0;
        #1;
        vecs++; if (sd_sclk !== 1'b0) begin errs++; $display("FAIL mid_rst_sclk: got %b want 0", sd_sclk); end
        vecs++; if (sd_mosi !== 1'b1) begin errs++; $display("FAIL mid_rst_mosi: got %b want 1", sd_mosi); end
        vecs++; if (sd_cs_n !== 1'b1) begin errs++; $display("FAIL mid_rst_cs_n: got %b want 1", sd_cs_n); end
        vecs++; if (spi_ack !== 1'b1) begin errs++; $display("FAIL mid_rst_ack: got %b want 1", spi_ack); end
        @(negedge clk); reset = 1'b1;
        access(2'd1, 1'b0, 8'h00, 10, s);
        vecs++; if (spi_data !== 8'h00) begin errs++; $display("FAIL mid_rst_status: got %h want 00", spi_data); end
        access(2'd3, 1'b0, 8'h00, 10, s);
        vecs++; if (spi_data !== 8'h3F) begin errs++; $display("FAIL mid_rst_clkdiv: got %h want 3f", spi_data); end
        access(2'd0, 1'b1, 8'h3C, 10, s);
        poll_busy(1100, n, first);
        vecs++; if (n != 1024) begin errs++; $display("FAIL post_rst_busy: got %0d want 1024", n); end
        access(2'd0, 1'b0, 8'h00, 10, s);
        vecs++; if (spi_data !== 8'h3C) begin errs++; $display("FAIL post_rst_rx: got %h want 3c", spi_data); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_slow_div();
        test_read_stall();
        test_back_to_back();
        test_ctrl_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
